// File: rtl/a0_uart_tx.sv
// a0_uart_tx: queues every change of the CPU a0 value and streams it LSB-byte-first over a UART line.
// Build option: define A0TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module a0_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   a0,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef A0TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic [31:0] mem [FIFO_DEPTH];
  logic [31:0] prev_a0, sh;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic push, pop, full, do_push, tick;
  always_comb begin
    push = a0 != prev_a0;
    pop = (state == IDLE) && (fifo_level != '0);
    full = fifo_level == LW'(FIFO_DEPTH);
    do_push = push && (!full || pop);
    tick = cnt == CW'(CLKS_PER_BIT - 1);
  end
  always_ff @(posedge clk)
    if (!rst && do_push) mem[wr_ptr] <= a0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      fifo_level <= '0;
      overflow <= 1'b0;
      prev_a0 <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      sh <= '0;
`ifdef A0TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      prev_a0 <= a0;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
      fifo_level <= fifo_level + LW'(do_push) - LW'(pop);
      cnt <= tick ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (pop) begin
          sh <= mem[rd_ptr];
          byte_idx <= '0;
          cnt <= '0;
          tx <= 1'b0;
          tx_busy <= 1'b1;
          state <= START;
        end
        START: if (tick) begin
          bit_idx <= '0;
          tx <= sh[0];
`ifdef A0TX_PARITY_EN
          par <= 1'b0;
`endif
          state <= DATA;
        end
        DATA: if (tick) begin
          sh <= sh >> 1;
`ifdef A0TX_PARITY_EN
          par <= par ^ sh[0];
          tx <= (bit_idx == 3'd7) ? par ^ sh[0] : sh[1];
          state <= (bit_idx == 3'd7) ? PARITY : DATA;
`else
          tx <= (bit_idx == 3'd7) ? 1'b1 : sh[1];
          state <= (bit_idx == 3'd7) ? STOP : DATA;
`endif
          bit_idx <= bit_idx + 1'b1;
        end
`ifdef A0TX_PARITY_EN
        PARITY: if (tick) begin
          tx <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          tx <= (byte_idx == 2'd3);
          tx_busy <= (byte_idx != 2'd3);
          byte_idx <= byte_idx + 1'b1;
          state <= (byte_idx == 2'd3) ? IDLE : START;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a0_uart_tx.sv
// tb_a0_uart_tx: directed vector bench decoding the UART line slot by slot.
module tb_a0_uart_tx;
  localparam int CPB = 4;
`ifdef A0TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  typedef struct packed {
    logic [31:0]     w;
    logic [3:0][7:0] b;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a0 = '0;
  logic tx, tx_busy, overflow;
  logic [2:0] fifo_level;
  int checks = 0;
  int errors = 0;
  vec_t vecs [5];
  vec_t ov [6];
  always #5 clk = ~clk;
  a0_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .a0(a0), .tx(tx), .tx_busy(tx_busy),
    .fifo_level(fifo_level), .overflow(overflow)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Entered one edge before the FSM enters START; leaves right after the word returns to IDLE.
  task automatic rx_word(input logic [3:0][7:0] b, input string nm);
    logic [10:0] got, exp;
    logic busy;
    busy = 1'b1;
    @(posedge clk); #1;
    chk({nm, " start_edge"}, {31'd0, tx}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      got = '0;
      for (int s = 0; s < FB; s++) begin
        repeat (CPB / 2) @(posedge clk);
        #1;
        got[s] = tx;
        busy &= tx_busy;
        repeat (CPB / 2) @(posedge clk);
        #1;
      end
`ifdef A0TX_PARITY_EN
      exp = {1'b1, ^b[i], b[i], 1'b0};
`else
      exp = {1'b0, 1'b1, b[i], 1'b0};
`endif
      chk($sformatf("%s byte%0d", nm, i), 32'(got), 32'(exp));
    end
    chk({nm, " busy_during"}, {31'd0, busy}, 32'd1);
    chk({nm, " idle_after"}, {30'd0, tx, tx_busy}, 32'd2);
  endtask
  initial begin
    logic act;
    vecs[0] = {32'h000000A5, 8'h00, 8'h00, 8'h00, 8'hA5};
    vecs[1] = {32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
    vecs[2] = {32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
    vecs[3] = {32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    vecs[4] = {32'h00000001, 8'h00, 8'h00, 8'h00, 8'h01};
    ov[0] = {32'h01020304, 8'h01, 8'h02, 8'h03, 8'h04};
    ov[1] = {32'h05060708, 8'h05, 8'h06, 8'h07, 8'h08};
    ov[2] = {32'h090A0B0C, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    ov[3] = {32'h0D0E0F10, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    ov[4] = {32'h11121314, 8'h11, 8'h12, 8'h13, 8'h14};
    ov[5] = {32'h15161718, 8'h15, 8'h16, 8'h17, 8'h18};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {27'd0, tx, tx_busy, fifo_level}, {27'd0, 1'b1, 1'b0, 3'd0});
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk) rst = 1'b0;
    act = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) act = 1'b1;
    end
    chk("idle_50", {31'd0, act}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) a0 = vecs[i].w;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d queued", i), {29'd0, fifo_level}, 32'd1);
      rx_word(vecs[i].b, $sformatf("v%0d", i));
      repeat (10) @(posedge clk);
      #1;
      chk($sformatf("v%0d quiet", i), {28'd0, tx_busy, fifo_level}, 32'd0);
    end
    @(negedge clk) a0 = ov[0].w;
    @(posedge clk);
    #1;
    chk("ov0 queued", {29'd0, fifo_level}, 32'd1);
    fork
      rx_word(ov[0].b, "ov0");
      begin
        for (int j = 1; j < 6; j++) @(negedge clk) a0 = ov[j].w;
        @(posedge clk);
        #1;
        chk("ov_full", {28'd0, overflow, fifo_level}, {28'd0, 1'b1, 3'd4});
      end
    join
    for (int j = 1; j < 5; j++) rx_word(ov[j].b, $sformatf("ov%0d", j));
    repeat (20) @(posedge clk);
    #1;
    chk("ov_sticky", {27'd0, overflow, tx_busy, fifo_level}, {27'd0, 1'b1, 1'b0, 3'd0});
    @(negedge clk) begin
      rst = 1'b1;
      a0 = '0;
    end
    @(posedge clk);
    #1;
    chk("ov_cleared", {31'd0, overflow}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) a0 = 32'h000000A5;
    @(posedge clk);
    #1;
    repeat (90) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst", {27'd0, tx, tx_busy, fifo_level}, {27'd0, 1'b1, 1'b0, 3'd0});
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("resend queued", {29'd0, fifo_level}, 32'd1);
    rx_word(vecs[0].b, "resend");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
